// File: rtl/uart_pkg.sv
// Shared UART line constants and transmitter FSM state type.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_param_if.sv
// Word-level handshake between a UART TX client and the transmitter.
// master drives the word strobe; slave reports line and buffer status.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);

  logic                 dv;
  logic [DATA_BITS-1:0] data;
  logic                 ready;
  logic                 active;
  logic                 serial;
  logic                 done;

  modport master (
    output dv, data,
    input  ready, active, serial, done
  );

  modport slave (
    input  dv, data,
    output ready, active, serial, done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter; bit_end strobes on the last clock of each bit.
// Dropping run restarts the period from zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_end
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-word holding buffer.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic                 full;
  logic [IW-1:0]        idx;
  logic                 stop_idx;
  logic                 run;
  logic                 bit_end;
  logic                 last_stop;
  logic                 start;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`else
  // parity sense has no effect without the parity bit
  if (PARITY_ODD > 1) begin : g_parity_odd_unused
  end
`endif

  assign run       = (state != IDLE);
  assign last_stop = (STOP_BITS == 1) || stop_idx;
  // the buffer drains either from idle or straight out of the last stop bit
  assign start     = full && (state == IDLE ||
                     (state == STOP && bit_end && last_stop));

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (i_Clock),
    .rst_n  (i_Rst_L),
    .run    (run),
    .bit_end(bit_end)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      hold        <= '0;
      shift       <= '0;
      full        <= 1'b0;
      idx         <= '0;
      stop_idx    <= 1'b0;
      o_TX_Ready  <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Serial <= IDLE_LEVEL;
      o_TX_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      o_TX_Done <= 1'b0;
      if (i_TX_DV && o_TX_Ready) begin
        hold       <= i_TX_Byte;
        full       <= 1'b1;
        o_TX_Ready <= 1'b0;
      end
      unique case (state)
        IDLE: ;
        START: if (bit_end) begin
          state       <= DATA;
          o_TX_Serial <= shift[0];
          shift       <= shift >> 1;
          idx         <= '0;
        end
        DATA: if (bit_end) begin
          if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state       <= PARITY;
            o_TX_Serial <= par;
`else
            state       <= STOP;
            o_TX_Serial <= IDLE_LEVEL;
            stop_idx    <= 1'b0;
`endif
          end else begin
            idx         <= idx + 1'b1;
            o_TX_Serial <= shift[0];
            shift       <= shift >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state       <= STOP;
          o_TX_Serial <= IDLE_LEVEL;
          stop_idx    <= 1'b0;
        end
`endif
        STOP: if (bit_end) begin
          if (!last_stop) begin
            stop_idx <= 1'b1;
          end else begin
            o_TX_Done <= 1'b1;
            if (!full) begin
              state       <= IDLE;
              o_TX_Active <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (start) begin
        state       <= START;
        o_TX_Serial <= START_LEVEL;
        shift       <= hold;
        full        <= 1'b0;
        o_TX_Ready  <= 1'b1;
        o_TX_Active <= 1'b1;
        idx         <= '0;
        stop_idx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par         <= (^hold) ^ 1'(PARITY_ODD);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: 8N1 even-parity and 5-bit/2-stop odd-parity instances.
// Line activity is checked cycle by cycle against a frame-list reference model.
module tb_uart_tx_param;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) ifa ();
  uart_tx_param_if #(.DATA_BITS(5)) ifb ();

  logic       sel_b = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] din = 8'h00;

  assign ifa.dv   = dv & ~sel_b;
  assign ifa.data = din;
  assign ifb.dv   = dv & sel_b;
  assign ifb.data = din[4:0];

  uart_tx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut_a (
    .i_Clock(clk), .i_Rst_L(rst_n),
    .i_TX_DV(ifa.dv), .i_TX_Byte(ifa.data),
    .o_TX_Ready(ifa.ready), .o_TX_Active(ifa.active),
    .o_TX_Serial(ifa.serial), .o_TX_Done(ifa.done)
  );

  uart_tx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)
  ) dut_b (
    .i_Clock(clk), .i_Rst_L(rst_n),
    .i_TX_DV(ifb.dv), .i_TX_Byte(ifb.data),
    .o_TX_Ready(ifb.ready), .o_TX_Active(ifb.active),
    .o_TX_Serial(ifb.serial), .o_TX_Done(ifb.done)
  );

  logic m_serial, m_done, m_active, m_ready;
  assign m_serial = sel_b ? ifb.serial : ifa.serial;
  assign m_done   = sel_b ? ifb.done   : ifa.done;
  assign m_active = sel_b ? ifb.active : ifa.active;
  assign m_ready  = sel_b ? ifb.ready  : ifa.ready;

  int total = 0;
  int bad = 0;

  bit   exp_line[$];
  int   exp_end[$];
  int   inj_at[$];
  logic [7:0] inj_w[$];

  function automatic int n_data();
    return sel_b ? 5 : 8;
  endfunction

  function automatic int frame_len();
    return CPB * (1 + n_data() + PAR + (sel_b ? 2 : 1));
  endfunction

  // expected line level for every clock of one frame, appended to the model
  task automatic push_frame(input logic [7:0] w);
    bit p;
    p = sel_b;
    for (int c = 0; c < CPB; c++) exp_line.push_back(1'b0);
    for (int i = 0; i < n_data(); i++) begin
      p = p ^ w[i];
      for (int c = 0; c < CPB; c++) exp_line.push_back(w[i]);
    end
    if (PAR == 1)
      for (int c = 0; c < CPB; c++) exp_line.push_back(p);
    for (int s = 0; s < (sel_b ? 2 : 1); s++)
      for (int c = 0; c < CPB; c++) exp_line.push_back(1'b1);
    exp_end.push_back(exp_line.size());
  endtask

  task automatic start_frame(input logic [7:0] w, input string name);
    exp_line.delete();
    exp_end.delete();
    push_frame(w);
    @(negedge clk);
    dv = 1'b1;
    din = w;
    @(negedge clk);
    dv = 1'b0;
    din = 8'($urandom);
    total++;
    if (m_ready !== 1'b0 || m_serial !== 1'b1) begin
      bad++;
      $display("FAIL %s accept ready=%b serial=%b want ready=0 serial=1",
               name, m_ready, m_serial);
    end
  endtask

  // sample k follows the k-th edge after the start bit began
  task automatic run_window(input int n, input string name);
    int  acc;
    int  f1;
    bit  e_ser, e_done, e_act, e_rdy;
    acc = -1;
    f1 = exp_end[0];
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e_ser = (k - 1 < exp_line.size()) ? exp_line[k - 1] : 1'b1;
      e_act = (k - 1 < exp_line.size());
      e_done = 1'b0;
      foreach (exp_end[i]) if (exp_end[i] == k - 1) e_done = 1'b1;
      e_rdy = !(acc > 0 && acc <= k && k <= f1);
      total++;
      if (m_serial !== e_ser || m_done !== e_done ||
          m_active !== e_act || m_ready !== e_rdy) begin
        bad++;
        $display("FAIL %s k=%0d got ser=%b done=%b act=%b rdy=%b want %b %b %b %b",
                 name, k, m_serial, m_done, m_active, m_ready,
                 e_ser, e_done, e_act, e_rdy);
      end
      if (inj_at.size() > 0 && inj_at[0] == k) begin
        dv = 1'b1;
        din = inj_w[0];
        if (e_rdy && acc < 0) begin
          acc = k + 1;
          push_frame(inj_w[0]);
        end
        void'(inj_at.pop_front());
        void'(inj_w.pop_front());
      end else begin
        dv = 1'b0;
        din = 8'($urandom);
      end
    end
    dv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dv = 1'b0;
    repeat (3) @(negedge clk);
    total += 2;
    if ({ifa.serial, ifa.active, ifa.done, ifa.ready} !== 4'b1001) begin
      bad++;
      $display("FAIL reset_a got ser/act/done/rdy=%b want 1001",
               {ifa.serial, ifa.active, ifa.done, ifa.ready});
    end
    if ({ifb.serial, ifb.active, ifb.done, ifb.ready} !== 4'b1001) begin
      bad++;
      $display("FAIL reset_b got ser/act/done/rdy=%b want 1001",
               {ifb.serial, ifb.active, ifb.done, ifb.ready});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] w;
    for (int t = 0; t < 6; t++) begin
      w = (t == 0) ? 8'hA5 : (t == 1) ? 8'h07 : 8'($urandom);
      start_frame(w, "single");
      run_window(frame_len() + 4, "single");
    end
  endtask

  task automatic test_back_to_back();
    start_frame(8'h55, "b2b");
    inj_at.push_back(10);
    inj_w.push_back(8'h0F);
    run_window(2 * frame_len() + 4, "b2b");
    start_frame(8'($urandom), "b2b_rand");
    inj_at.push_back($urandom_range(1, frame_len() - 1));
    inj_w.push_back(8'($urandom));
    run_window(2 * frame_len() + 4, "b2b_rand");
  endtask

  task automatic test_backpressure();
    int k1;
    k1 = $urandom_range(1, frame_len() - 12);
    start_frame(8'($urandom), "bp");
    for (int i = 0; i < 3; i++) begin
      inj_at.push_back(k1 + 4 * i);
      inj_w.push_back(8'($urandom));
    end
    run_window(2 * frame_len() + 4, "bp");
  endtask

  task automatic test_reset_mid();
    int viol;
    viol = 0;
    start_frame(8'h3C, "rst_mid");
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      dv = (k == 5);
      din = 8'hC3;
    end
    dv = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ifa.serial, ifa.active, ifa.done, ifa.ready} !== 4'b1001) begin
      bad++;
      $display("FAIL rst_mid got ser/act/done/rdy=%b want 1001",
               {ifa.serial, ifa.active, ifa.done, ifa.ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ifa.done !== 1'b0 || ifa.serial !== 1'b1 || ifa.active !== 1'b0)
        viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL rst_mid_after got %0d bad cycles want 0", viol);
    end
  endtask

  task automatic test_width_stop();
    sel_b = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      start_frame((t == 0) ? 8'h1F : 8'($urandom), "w5s2");
      run_window(frame_len() + 4, "w5s2");
    end
    start_frame(8'($urandom), "w5s2_b2b");
    inj_at.push_back($urandom_range(1, frame_len() - 1));
    inj_w.push_back(8'($urandom));
    run_window(2 * frame_len() + 4, "w5s2_b2b");
    sel_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_width_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per serial bit (legal range >= 2).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning parity sense (0 even, 1 odd); used only with UART_TX_PARITY_EN.
REQ-005 SHALL have port i_Clock  input  1  system clock, rising-edge active.
REQ-006 SHALL have port i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_TX_DV  input  1  byte-valid strobe, sampled on rising edge.
REQ-008 SHALL have port i_TX_Byte  input  DATA_BITS  data word to send.
REQ-009 SHALL have port o_TX_Ready  output  1  holding buffer empty, i.e. the next word is accepted.
REQ-010 SHALL have port o_TX_Active  output  1  frame in progress.
REQ-011 SHALL have port o_TX_Serial  output  1  serial line, idle high.
REQ-012 SHALL have port o_TX_Done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-013 SHALL accept a word into a one-entry holding buffer on the rising edge at which i_TX_DV=1 and o_TX_Ready=1; i_TX_DV with o_TX_Ready=0 SHALL be ignored, with no loss of the buffered word.
REQ-014 SHALL clear o_TX_Ready on the edge that loads the buffer and set it on the edge that transfers the buffer to the shifter.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP: IDLE->START when the buffer is full; START->DATA; DATA->PARITY after the last data bit if parity is compiled in, else DATA->STOP; PARITY->STOP; STOP->START if the buffer is full at stop end, else STOP->IDLE.
REQ-016 SHALL, on the IDLE->START edge, load the shifter from the buffer and drive o_TX_Serial=0; serial start therefore begins one clock after acceptance.
REQ-017 SHALL hold each start, data, parity and stop bit for exactly CLKS_PER_BIT clocks.
REQ-018 SHALL transmit data LSB first, bits 0..DATA_BITS-1.
REQ-019 SHALL drive the stop level (1) for STOP_BITS x CLKS_PER_BIT clocks.
REQ-020 SHALL drive o_TX_Serial=1 in IDLE.
REQ-021 SHALL pulse o_TX_Done for one cycle on the edge that ends the final stop bit.
REQ-022 SHALL, on a back-to-back frame, start the next frame on that same edge, with no idle bit between frames and with o_TX_Active remaining 1.
REQ-023 SHALL hold o_TX_Active=1 in START through STOP and drive it 0 in IDLE.
REQ-024 SHALL size the bit-period counter at $clog2(CLKS_PER_BIT) bits, with wrap at CLKS_PER_BIT-1, and size the bit index at $clog2(DATA_BITS) bits.
REQ-025 SHALL leave the frame in progress unaffected by i_TX_Byte changes after acceptance.

Reset
REQ-026 SHALL, while i_Rst_L=0 and regardless of clock, force o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, FSM=IDLE, counters=0 and buffer empty.
REQ-027 SHALL, on reset mid-frame, abandon the frame and discard the buffered word; no o_TX_Done SHALL be issued for either.

Configuration
REQ-028 SHALL, with UART_TX_PARITY_EN defined, insert one parity bit after the data bits: even parity is the XOR of the data bits, and odd parity is its inverse when PARITY_ODD=1.
REQ-029 SHALL, without UART_TX_PARITY_EN, compile out the PARITY state and its logic; frame length is then 1+DATA_BITS+STOP_BITS bits.

Structure
REQ-030 SHALL place the FSM state typedef and the line-level constants (IDLE_LEVEL=1, START_LEVEL=0) in shared package uart_pkg.
REQ-031 SHALL implement bit timing in sub-module uart_bit_timer (counter plus one-cycle bit_end strobe, restartable).

Verification (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-032 SHALL cover single frame: DV with 0xA5 -> serial 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; o_TX_Done pulses once at clock 40 after start.
REQ-033 SHALL cover back-to-back: 0x55 then 0x0F accepted mid-frame -> the second start bit follows the first stop bit directly; 2 Done pulses 40 clocks apart; o_TX_Active stays 1.
REQ-034 SHALL cover backpressure: three DV strobes during frame 1 -> only the first is buffered; exactly 2 frames are sent; o_TX_Ready=0 until frame 2 starts.
REQ-035 SHALL cover reset mid-frame: i_Rst_L low during data bit 3 -> o_TX_Serial=1 and o_TX_Active=0 immediately; no Done pulse; o_TX_Ready=1.
REQ-036 SHALL cover parity (UART_TX_PARITY_EN, PARITY_ODD=0): 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 11 bits.
REQ-037 SHALL cover width/stop: DATA_BITS=5, STOP_BITS=2, 0x1F -> 5 data ones; stop high for 8 clocks before Done.
